// File: rtl/interleaver_frame_arbiter_if.sv
// interleaver_frame_arbiter_if: FIFO-side, Interleaver-side and status signals of the frame arbiter
interface interleaver_frame_arbiter_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 ch0_en;
    logic                 ch1_en;
    logic                 fifo0_in_data;
    logic                 fifo0_in_re;
    logic                 fifo0_in_empty;
    logic                 fifo1_in_data;
    logic                 fifo1_in_re;
    logic                 fifo1_in_empty;
    logic                 il_data;
    logic                 il_re;
    logic                 il_empty;
    logic                 grant_ch;
    logic                 busy;
    logic                 frame_start;
    logic                 frame_done;
    logic [CNT_WIDTH-1:0] frame_cnt0;
    logic [CNT_WIDTH-1:0] frame_cnt1;
    modport slave (
        input  ch0_en, ch1_en, fifo0_in_data, fifo0_in_empty, fifo1_in_data, fifo1_in_empty, il_re,
        output fifo0_in_re, fifo1_in_re, il_data, il_empty, grant_ch, busy, frame_start, frame_done,
               frame_cnt0, frame_cnt1
    );
    modport master (
        output ch0_en, ch1_en, fifo0_in_data, fifo0_in_empty, fifo1_in_data, fifo1_in_empty, il_re,
        input  fifo0_in_re, fifo1_in_re, il_data, il_empty, grant_ch, busy, frame_start, frame_done,
               frame_cnt0, frame_cnt1
    );
endinterface

// File: rtl/interleaver_frame_arbiter.sv
// interleaver_frame_arbiter: round-robin, frame-granular sharing of one Interleaver between two 1-bit FIFOs
module interleaver_frame_arbiter #(
    parameter int ROW_NUMBER = 8,
    parameter int COL_NUMBER = 8,
    parameter int CNT_WIDTH  = 16
) (
    input logic                        clk,
    input logic                        rst_n,
    interleaver_frame_arbiter_if.slave bus
);
    localparam int FRAME_BITS = ROW_NUMBER * COL_NUMBER;
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] XFER = 1'b1;
    logic [0:0]           state;
    logic                 rr_ptr;
    logic                 grant;
    logic                 sel_d;
    logic                 rd_d;
    logic                 start;
    logic [BW-1:0]        bit_cnt;
    logic [CNT_WIDTH-1:0] cnt0;
    logic [CNT_WIDTH-1:0] cnt1;
    logic [1:0]           req;
    logic                 winner;
    logic                 xfer;
    logic                 g_empty;
    logic                 rd;
    logic                 last;
    // Arbitration request/winner and the gated read of the granted FIFO
    always_comb begin
        req     = {bus.ch1_en & ~bus.fifo1_in_empty, bus.ch0_en & ~bus.fifo0_in_empty};
        winner  = req[rr_ptr] ? rr_ptr : ~rr_ptr;
        xfer    = state == XFER;
        g_empty = grant ? bus.fifo1_in_empty : bus.fifo0_in_empty;
        rd      = xfer & bus.il_re & ~g_empty;
        last    = rd & (bit_cnt == BW'(FRAME_BITS - 1));
    end
    assign bus.fifo0_in_re = rd & ~grant;
    assign bus.fifo1_in_re = rd & grant;
    assign bus.il_empty    = ~xfer | g_empty;
    // Data follows the FIFO read by one cycle, so the mux uses the grant captured at the read
    assign bus.il_data     = rd_d & (sel_d ? bus.fifo1_in_data : bus.fifo0_in_data);
    assign bus.grant_ch    = grant;
    assign bus.busy        = xfer;
    assign bus.frame_start = start;
    assign bus.frame_done  = last;
    assign bus.frame_cnt0  = cnt0;
    assign bus.frame_cnt1  = cnt1;
    // Grant a channel in IDLE, count frame bits in XFER and hand over on the last read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= 1'b0;
            grant   <= 1'b0;
            start   <= 1'b0;
            bit_cnt <= '0;
            cnt0    <= '0;
            cnt1    <= '0;
        end else begin
            start <= 1'b0;
            if (state == IDLE) begin
                if (|req) begin
                    grant <= winner;
                    start <= 1'b1;
                    state <= XFER;
                end
            end else if (rd) begin
                bit_cnt <= last ? '0 : bit_cnt + 1'b1;
                if (last) begin
                    if (grant) cnt1 <= cnt1 + 1'b1;
                    else cnt0 <= cnt0 + 1'b1;
                    rr_ptr <= ~grant;
                    state  <= IDLE;
                end
            end
        end
    end
    // Remember which FIFO was read last cycle and whether a read happened at all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_d <= 1'b0;
            rd_d  <= 1'b0;
        end else begin
            rd_d <= rd;
            if (rd) sel_d <= grant;
        end
    end
endmodule

// File: tb/tb_interleaver_frame_arbiter.sv
// tb_interleaver_frame_arbiter: FIFO models plus an in-order per-channel scoreboard around the arbiter
module tb_interleaver_frame_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    interleaver_frame_arbiter_if #(.CNT_WIDTH(16)) ifc ();
    interleaver_frame_arbiter #(.ROW_NUMBER(8), .COL_NUMBER(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave)
    );
    int checks = 0;
    int errors = 0;
    bit q0[$], q1[$], exp0[$], exp1[$];
    logic d0 = 1'b0, d1 = 1'b0, mon_rd = 1'b0, mon_ch = 1'b0;
    bit rand_re = 1'b0, after_done = 1'b0;
    int cur_reads, nstart, ndone, n_re0, n_re1, bad, empty_busy, gap_viol;
    int g_seq[$], frame_len[$];

    // Scoreboard: every FIFO read must show up on il_data one cycle later, in order per channel
    always @(negedge clk) begin
        bit e;
        if (mon_rd) begin
            if (mon_ch ? exp1.size() == 0 : exp0.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underflow ch%0d read with nothing expected", mon_ch);
            end else begin
                e = mon_ch ? exp1.pop_front() : exp0.pop_front();
                if (rst_n) begin
                    checks++;
                    if (ifc.il_data !== e) begin
                        errors++;
                        $display("FAIL il_data ch%0d got %b exp %b", mon_ch, ifc.il_data, e);
                    end
                end
            end
        end
    end

    task automatic clear_stats();
        cur_reads = 0; nstart = 0; ndone = 0; n_re0 = 0; n_re1 = 0;
        bad = 0; empty_busy = 0; gap_viol = 0; after_done = 0;
        g_seq.delete(); frame_len.delete();
    endtask

    task automatic push(input bit ch, input int n);
        bit b;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom_range(0, 1));
            if (ch) begin q1.push_back(b); exp1.push_back(b); end
            else begin q0.push_back(b); exp0.push_back(b); end
        end
        ifc.fifo0_in_empty = q0.size() == 0;
        ifc.fifo1_in_empty = q1.size() == 0;
    endtask

    task automatic tick();
        logic r0, r1;
        r0 = ifc.fifo0_in_re;
        r1 = ifc.fifo1_in_re;
        @(posedge clk);
        #1;
        mon_rd = r0 | r1;
        mon_ch = r1;
        if ((r0 && q0.size() == 0) || (r1 && q1.size() == 0)) begin
            checks++; errors++;
            $display("FAIL fifo_underflow re0 %b re1 %b on empty FIFO", r0, r1);
        end
        if (r0 && q0.size() > 0) d0 = q0.pop_front();
        if (r1 && q1.size() > 0) d1 = q1.pop_front();
        ifc.fifo0_in_data  = d0;
        ifc.fifo1_in_data  = d1;
        ifc.fifo0_in_empty = q0.size() == 0;
        ifc.fifo1_in_empty = q1.size() == 0;
        #1;
    endtask

    task automatic cyc();
        logic r0, r1;
        ifc.il_re = rand_re ? 1'($urandom_range(0, 1)) : 1'b1;
        #1;
        r0 = ifc.fifo0_in_re;
        r1 = ifc.fifo1_in_re;
        if (ifc.frame_start) begin g_seq.push_back(int'(ifc.grant_ch)); cur_reads = 0; nstart++; end
        if (r0 | r1) begin
            cur_reads++; n_re0 += int'(r0); n_re1 += int'(r1);
            if (!ifc.busy || ifc.il_empty || (r0 && r1) || (r0 && ifc.grant_ch) || (r1 && !ifc.grant_ch)) bad++;
        end
        if (ifc.busy && ifc.il_empty) empty_busy++;
        if (after_done && ifc.busy) gap_viol++;
        after_done = ifc.frame_done;
        if (ifc.frame_done) begin frame_len.push_back(cur_reads); ndone++; end
        tick();
    endtask

    task automatic run_frames(input int n, input int budget);
        int c = 0;
        while (ndone < n && c < budget) begin cyc(); c++; end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
        d0 = 1'b0; d1 = 1'b0; mon_rd = 1'b0; rand_re = 1'b0;
        ifc.ch0_en = 1'b0; ifc.ch1_en = 1'b0; ifc.il_re = 1'b0;
        ifc.fifo0_in_data = 1'b0; ifc.fifo1_in_data = 1'b0;
        ifc.fifo0_in_empty = 1'b1; ifc.fifo1_in_empty = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        clear_stats();
    endtask

    task automatic test_reset();
        logic [7:0] o;
        rst_n = 1'b0;
        ifc.ch0_en = 1'b0; ifc.ch1_en = 1'b0; ifc.il_re = 1'b1;
        d0 = 1'b1; d1 = 1'b1;
        ifc.fifo0_in_data = 1'b1; ifc.fifo1_in_data = 1'b1;
        ifc.fifo0_in_empty = 1'b1; ifc.fifo1_in_empty = 1'b1;
        tick(); tick();
        for (int k = 0; k < 2; k++) begin
            o = {ifc.grant_ch, ifc.busy, ifc.frame_start, ifc.frame_done, ifc.il_empty,
                 ifc.fifo0_in_re, ifc.fifo1_in_re, ifc.il_data};
            checks++;
            if (o !== 8'b0000_1000) begin errors++; $display("FAIL reset_outs[%0d] got %b exp 00001000", k, o); end
            checks++;
            if (ifc.frame_cnt0 !== 16'd0 || ifc.frame_cnt1 !== 16'd0) begin
                errors++; $display("FAIL reset_cnt[%0d] got %0d/%0d exp 0/0", k, ifc.frame_cnt0, ifc.frame_cnt1);
            end
            rst_n = 1'b1;
            tick(); tick();
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        push(0, 64);
        ifc.ch0_en = 1'b1; ifc.ch1_en = 1'b1;
        run_frames(1, 300);
        checks++;
        if (ndone !== 1) begin errors++; $display("FAIL single_done got %0d exp 1", ndone); end
        checks++;
        if (g_seq.size() !== 1 || g_seq[0] !== 0) begin errors++; $display("FAIL single_grant got n=%0d exp one grant of ch0", g_seq.size()); end
        checks++;
        if (n_re0 !== 64 || n_re1 !== 0) begin errors++; $display("FAIL single_reads got %0d/%0d exp 64/0", n_re0, n_re1); end
        checks++;
        if (frame_len.size() !== 1 || frame_len[0] !== 64) begin errors++; $display("FAIL single_done_pos got %0d exp 64", frame_len[0]); end
        checks++;
        if (ifc.frame_cnt0 !== 16'd1 || ifc.busy !== 1'b0) begin
            errors++; $display("FAIL single_cnt got cnt0 %0d busy %b exp 1 0", ifc.frame_cnt0, ifc.busy);
        end
        cyc();
        checks++;
        if (exp0.size() !== 0 || bad !== 0 || gap_viol !== 0) begin
            errors++; $display("FAIL single_drain got left %0d bad %0d gap %0d exp 0 0 0", exp0.size(), bad, gap_viol);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] gs;
        int wrong_len;
        do_reset();
        push(0, 192); push(1, 192);
        ifc.ch0_en = 1'b1; ifc.ch1_en = 1'b1;
        run_frames(4, 600);
        gs = '1;
        for (int i = 0; i < 4 && i < g_seq.size(); i++) gs[i] = g_seq[i][0];
        wrong_len = 0;
        foreach (frame_len[i]) if (frame_len[i] != 64) wrong_len++;
        checks++;
        if (ndone !== 4 || gs !== 4'b1010) begin errors++; $display("FAIL rr_grants got done %0d seq %b exp 4 1010", ndone, gs); end
        checks++;
        if (ifc.frame_cnt0 !== 16'd2 || ifc.frame_cnt1 !== 16'd2) begin
            errors++; $display("FAIL rr_cnt got %0d/%0d exp 2/2", ifc.frame_cnt0, ifc.frame_cnt1);
        end
        checks++;
        if (bad !== 0 || gap_viol !== 0 || wrong_len !== 0) begin
            errors++; $display("FAIL rr_protocol got bad %0d gap %0d badlen %0d exp 0 0 0", bad, gap_viol, wrong_len);
        end
    endtask

    task automatic test_empty_gap();
        do_reset();
        push(0, 30); push(1, 64);
        ifc.ch0_en = 1'b1; ifc.ch1_en = 1'b1;
        repeat (60) cyc();
        checks++;
        if (ndone !== 0 || n_re0 !== 30 || n_re1 !== 0) begin
            errors++; $display("FAIL gap_hold got done %0d re0 %0d re1 %0d exp 0 30 0", ndone, n_re0, n_re1);
        end
        checks++;
        if (empty_busy < 20 || ifc.grant_ch !== 1'b0 || ifc.busy !== 1'b1) begin
            errors++; $display("FAIL gap_empty got empty_cycles %0d grant %b busy %b exp >=20 0 1", empty_busy, ifc.grant_ch, ifc.busy);
        end
        push(0, 34);
        run_frames(1, 200);
        checks++;
        if (ndone !== 1 || frame_len[0] !== 64 || g_seq.size() !== 1 || n_re1 !== 0) begin
            errors++; $display("FAIL gap_resume got done %0d len %0d grants %0d re1 %0d exp 1 64 1 0", ndone, frame_len[0], g_seq.size(), n_re1);
        end
        checks++;
        if (ifc.frame_cnt0 !== 16'd1 || bad !== 0) begin errors++; $display("FAIL gap_cnt got %0d bad %0d exp 1 0", ifc.frame_cnt0, bad); end
    endtask

    task automatic test_enables();
        int c = 0;
        int ch1_grants = 0;
        do_reset();
        push(0, 256); push(1, 64);
        ifc.ch0_en = 1'b1; ifc.ch1_en = 1'b0;
        run_frames(3, 600);
        foreach (g_seq[i]) if (g_seq[i] != 0) ch1_grants++;
        checks++;
        if (ndone !== 3 || ch1_grants !== 0 || n_re1 !== 0) begin
            errors++; $display("FAIL en_only_ch0 got done %0d ch1grants %0d re1 %0d exp 3 0 0", ndone, ch1_grants, n_re1);
        end
        checks++;
        if (ifc.frame_cnt0 !== 16'd3 || ifc.frame_cnt1 !== 16'd0) begin
            errors++; $display("FAIL en_cnt got %0d/%0d exp 3/0", ifc.frame_cnt0, ifc.frame_cnt1);
        end
        clear_stats();
        while (cur_reads < 10 && c < 50) begin cyc(); c++; end
        ifc.ch0_en = 1'b0;
        run_frames(1, 200);
        checks++;
        if (ndone !== 1 || frame_len[0] !== 64 || ifc.frame_cnt0 !== 16'd4) begin
            errors++; $display("FAIL en_drop got done %0d len %0d cnt0 %0d exp 1 64 4", ndone, frame_len[0], ifc.frame_cnt0);
        end
        repeat (5) cyc();
        checks++;
        if (nstart !== 1 || ifc.busy !== 1'b0) begin errors++; $display("FAIL en_idle got starts %0d busy %b exp 1 0", nstart, ifc.busy); end
    endtask

    task automatic test_reset_abort();
        int c = 0;
        logic [7:0] o;
        do_reset();
        push(1, 128);
        ifc.ch0_en = 1'b1; ifc.ch1_en = 1'b1;
        while (cur_reads < 40 && c < 200) begin cyc(); c++; end
        checks++;
        if (cur_reads !== 40 || g_seq.size() !== 1 || g_seq[0] !== 1) begin
            errors++; $display("FAIL abort_setup got reads %0d grants %0d exp 40 ch1", cur_reads, g_seq.size());
        end
        rst_n = 1'b0;
        #1;
        o = {ifc.grant_ch, ifc.busy, ifc.frame_start, ifc.frame_done, ifc.il_empty,
             ifc.fifo0_in_re, ifc.fifo1_in_re, ifc.il_data};
        checks++;
        if (o !== 8'b0000_1000) begin errors++; $display("FAIL abort_outs got %b exp 00001000", o); end
        checks++;
        if (ifc.frame_cnt0 !== 16'd0 || ifc.frame_cnt1 !== 16'd0) begin
            errors++; $display("FAIL abort_cnt got %0d/%0d exp 0/0", ifc.frame_cnt0, ifc.frame_cnt1);
        end
        do_reset();
        push(0, 64); push(1, 64);
        ifc.ch0_en = 1'b1; ifc.ch1_en = 1'b1;
        run_frames(1, 200);
        checks++;
        if (ndone !== 1 || g_seq[0] !== 0 || frame_len[0] !== 64) begin
            errors++; $display("FAIL abort_next got done %0d grant %0d len %0d exp 1 0 64", ndone, g_seq[0], frame_len[0]);
        end
        checks++;
        if (ifc.frame_cnt0 !== 16'd1 || ifc.frame_cnt1 !== 16'd0) begin
            errors++; $display("FAIL abort_next_cnt got %0d/%0d exp 1/0", ifc.frame_cnt0, ifc.frame_cnt1);
        end
    endtask

    task automatic test_random_re();
        int wrong_len = 0;
        int wrong_seq = 0;
        do_reset();
        rand_re = 1'b1;
        push(0, 320); push(1, 320);
        ifc.ch0_en = 1'b1; ifc.ch1_en = 1'b1;
        run_frames(10, 4000);
        foreach (frame_len[i]) if (frame_len[i] != 64) wrong_len++;
        foreach (g_seq[i]) if (g_seq[i] != i % 2) wrong_seq++;
        checks++;
        if (ndone !== 10 || wrong_len !== 0 || wrong_seq !== 0) begin
            errors++; $display("FAIL rand_frames got done %0d badlen %0d badseq %0d exp 10 0 0", ndone, wrong_len, wrong_seq);
        end
        checks++;
        if (ifc.frame_cnt0 !== 16'd5 || ifc.frame_cnt1 !== 16'd5 || bad !== 0) begin
            errors++; $display("FAIL rand_cnt got %0d/%0d bad %0d exp 5/5 0", ifc.frame_cnt0, ifc.frame_cnt1, bad);
        end
        repeat (3) cyc();
        checks++;
        if (exp0.size() !== 0 || exp1.size() !== 0) begin
            errors++; $display("FAIL rand_drain got left %0d/%0d exp 0/0", exp0.size(), exp1.size());
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_empty_gap();
        test_enables();
        test_reset_abort();
        test_random_re();
        #20;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
